// File: rtl/bus_arbiter4_32.sv
// Round-robin arbiter and burst sequencer for the shared 32-bit 4:1 mux.
// One requester is granted at a time. The grant is held for a whole burst,
// up to MAX_BURST beats. Each accepted beat is registered into a
// single-entry valid/ready output stage.

// 4:1 datapath multiplexer shared by the four requesters
module mux4_32 (
   input  logic [31:0] i0,
   input  logic [31:0] i1,
   input  logic [31:0] i2,
   input  logic [31:0] i3,
   input  logic        s1,
   input  logic        s0,
   output logic [31:0] z
);

   // select one of the four inputs
   always_comb begin
      case ({s1, s0})
         2'd0:    z = i0;
         2'd1:    z = i1;
         2'd2:    z = i2;
         default: z = i3;
      endcase
   end

endmodule

module bus_arbiter4_32 #(
   parameter int WIDTH     = 32,
   parameter int MAX_BURST = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       req,
   input  logic [3:0]       last,
   input  logic [WIDTH-1:0] d0,
   input  logic [WIDTH-1:0] d1,
   input  logic [WIDTH-1:0] d2,
   input  logic [WIDTH-1:0] d3,
   output logic [3:0]       ack,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic [1:0]       out_src,
   input  logic             out_ready,
   output logic             busy
);

   typedef enum logic {IDLE, BUSY} state_t;

   localparam logic [3:0] CNT_MAX = 4'(MAX_BURST - 1);

   state_t           state_reg, state_next;
   logic [1:0]       sel_reg, sel_next;
   logic [1:0]       last_grant_reg, last_grant_next;
   logic [3:0]       beat_cnt_reg, beat_cnt_next;
   logic [WIDTH-1:0] out_data_reg, out_data_next;
   logic             out_valid_reg, out_valid_next;
   logic             out_last_reg, out_last_next;
   logic [1:0]       out_src_reg, out_src_next;
   logic [3:0]       ack_comb;
   logic             load;
   logic             beat_last;
   logic [WIDTH-1:0] mux_out;
   logic [1:0]       rr_idx [4];
   logic [3:0]       rr_req;
   logic [1:0]       pick;

   mux4_32 u_mux (
      .i0 (d0),
      .i1 (d1),
      .i2 (d2),
      .i3 (d3),
      .s1 (sel_reg[1]),
      .s0 (sel_reg[0]),
      .z  (mux_out)
   );

   // Candidate order starts just after the previous winner and wraps.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_rr
         assign rr_idx[gi] = 2'(last_grant_reg + 2'(gi + 1));
         assign rr_req[gi] = req[rr_idx[gi]];
      end
   endgenerate

   // first requesting candidate in rotated order wins (lowest gi has priority)
   always_comb begin
      pick = rr_idx[0];
      for (int k = 3; k >= 0; k--) begin
         if (rr_req[k]) pick = rr_idx[k];
      end
   end

   // A beat ends the burst on its own last flag or when the cap is reached.
   assign beat_last = last[sel_reg] | (beat_cnt_reg == CNT_MAX);

   // next-state, grant bookkeeping, output-stage load and ack pulse
   always_comb begin
      state_next      = state_reg;
      sel_next        = sel_reg;
      last_grant_next = last_grant_reg;
      beat_cnt_next   = beat_cnt_reg;
      out_data_next   = out_data_reg;
      out_valid_next  = out_valid_reg;
      out_last_next   = out_last_reg;
      out_src_next    = out_src_reg;
      ack_comb        = 4'b0000;
      load            = 1'b0;

      case (state_reg)
         IDLE: begin
            if (|req) begin
               sel_next      = pick;
               beat_cnt_next = 4'd0;
               state_next    = BUSY;
            end
         end
         BUSY: begin
            load = req[sel_reg] & (~out_valid_reg | out_ready);
            if (!req[sel_reg]) begin
               // requester dropped out mid-grant: release without a beat
               last_grant_next = sel_reg;
               state_next      = IDLE;
            end else if (load) begin
               ack_comb       = 4'b0001 << sel_reg;
               out_data_next  = mux_out;
               out_src_next   = sel_reg;
               out_valid_next = 1'b1;
               out_last_next  = beat_last;
               beat_cnt_next  = beat_cnt_reg + 4'd1;
               if (beat_last) begin
                  last_grant_next = sel_reg;
                  state_next      = IDLE;
               end
            end
         end
         default: state_next = IDLE;
      endcase

      if (out_valid_reg & out_ready & ~load) out_valid_next = 1'b0;
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   // grant, counter and output-stage registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_reg        <= 2'd0;
         last_grant_reg <= 2'd3;
         beat_cnt_reg   <= 4'd0;
         out_data_reg   <= '0;
         out_valid_reg  <= 1'b0;
         out_last_reg   <= 1'b0;
         out_src_reg    <= 2'd0;
      end else begin
         sel_reg        <= sel_next;
         last_grant_reg <= last_grant_next;
         beat_cnt_reg   <= beat_cnt_next;
         out_data_reg   <= out_data_next;
         out_valid_reg  <= out_valid_next;
         out_last_reg   <= out_last_next;
         out_src_reg    <= out_src_next;
      end
   end

   assign ack       = ack_comb;
   assign sel       = sel_reg;
   assign out_data  = out_data_reg;
   assign out_valid = out_valid_reg;
   assign out_last  = out_last_reg;
   assign out_src   = out_src_reg;
   assign busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_bus_arbiter4_32.sv
// Directed bench for bus_arbiter4_32 (built with a burst cap of 4).
module tb_bus_arbiter4_32;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [3:0]  req;
   logic [3:0]  last;
   logic [31:0] d0, d1, d2, d3;
   logic [3:0]  ack;
   logic [1:0]  sel;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_src;
   logic        out_ready;
   logic        busy;

   int n_assert = 0;
   int n_fail   = 0;

   bus_arbiter4_32 #(.WIDTH(32), .MAX_BURST(4)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .last      (last),
      .d0        (d0),
      .d1        (d1),
      .d2        (d2),
      .d3        (d3),
      .ack       (ack),
      .sel       (sel),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_last  (out_last),
      .out_src   (out_src),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, " out_data"},  out_data,       32'd0);
      chk({tag, " out_last"},  32'(out_last),  32'd0);
      chk({tag, " out_src"},   32'(out_src),   32'd0);
      chk({tag, " ack"},       32'(ack),       32'd0);
      chk({tag, " busy"},      32'(busy),      32'd0);
      chk({tag, " sel"},       32'(sel),       32'd0);
   endtask

   initial begin
      // reset held with every requester asking
      reset_n = 1'b0; req = 4'hF; last = 4'hF; out_ready = 1'b1;
      d0 = 32'd0; d1 = 32'd1; d2 = 32'd2; d3 = 32'd3;
      cyc(); cyc();
      chk_reset_vals("reset");

      // round-robin: single-beat bursts from everyone, expect 0,1,2,3,0
      reset_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cyc();
         chk($sformatf("rr%0d sel", k),  32'(sel),  32'(k % 4));
         chk($sformatf("rr%0d busy", k), 32'(busy), 32'd1);
         chk($sformatf("rr%0d ack", k),  32'(ack),  32'(4'b0001 << (k % 4)));
         cyc();
         chk($sformatf("rr%0d out_valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("rr%0d out_src", k),   32'(out_src),   32'(k % 4));
         chk($sformatf("rr%0d out_data", k),  out_data,       32'(k % 4));
         chk($sformatf("rr%0d out_last", k),  32'(out_last),  32'd1);
         chk($sformatf("rr%0d bubble", k),    32'(busy),      32'd0);
         chk($sformatf("rr%0d ack idle", k),  32'(ack),       32'd0);
      end
      req = 4'h0;
      cyc();
      chk("rr drain out_valid", 32'(out_valid), 32'd0);

      // single beat from requester 1
      req = 4'b0010; last = 4'b0010; d1 = 32'h00000001;
      #1;
      chk("single idle ack", 32'(ack), 32'd0);
      cyc();
      chk("single sel",  32'(sel),  32'd1);
      chk("single busy", 32'(busy), 32'd1);
      chk("single ack",  32'(ack),  32'b0010);
      cyc();
      req = 4'b0000;
      #1;
      chk("single out_data",  out_data,       32'h00000001);
      chk("single out_src",   32'(out_src),   32'd1);
      chk("single out_last",  32'(out_last),  32'd1);
      chk("single out_valid", 32'(out_valid), 32'd1);
      chk("single back idle", 32'(busy),      32'd0);
      chk("single ack pulse", 32'(ack),       32'd0);
      cyc();
      chk("single drain", 32'(out_valid), 32'd0);

      // backpressure on a requester-2 beat
      req = 4'b0100; last = 4'b0100; d2 = 32'h00000002; out_ready = 1'b0;
      cyc();
      chk("bp sel", 32'(sel), 32'd2);
      chk("bp ack", 32'(ack), 32'b0100);
      cyc();
      d2 = 32'h0000DEAD;
      #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp out_data",  out_data,       32'h00000002);
      for (int k = 0; k < 3; k++) begin
         cyc();
         chk($sformatf("bp stall%0d busy", k),  32'(busy),      32'd1);
         chk($sformatf("bp stall%0d ack", k),   32'(ack),       32'd0);
         chk($sformatf("bp stall%0d data", k),  out_data,       32'h00000002);
         chk($sformatf("bp stall%0d valid", k), 32'(out_valid), 32'd1);
         chk($sformatf("bp stall%0d src", k),   32'(out_src),   32'd2);
      end
      out_ready = 1'b1;
      #1;
      chk("bp release ack", 32'(ack), 32'b0100);
      cyc();
      req = 4'b0000;
      #1;
      chk("bp next data",  out_data,       32'h0000DEAD);
      chk("bp next valid", 32'(out_valid), 32'd1);
      cyc();
      chk("bp drain", 32'(out_valid), 32'd0);

      // burst cap of 4 on requester 3 while requester 0 waits
      req = 4'b1001; last = 4'b0000; d0 = 32'h00000030;
      cyc();
      chk("cap sel",  32'(sel),  32'd3);
      chk("cap busy", 32'(busy), 32'd1);
      for (int b = 0; b < 4; b++) begin
         d3 = 32'h300 + 32'(b);
         #1;
         chk($sformatf("cap b%0d ack", b), 32'(ack), 32'b1000);
         cyc();
         chk($sformatf("cap b%0d data", b),  out_data,       32'h300 + 32'(b));
         chk($sformatf("cap b%0d src", b),   32'(out_src),   32'd3);
         chk($sformatf("cap b%0d valid", b), 32'(out_valid), 32'd1);
         chk($sformatf("cap b%0d last", b),  32'(out_last),  32'(b == 3));
         chk($sformatf("cap b%0d busy", b),  32'(busy),      32'(b != 3));
      end
      chk("cap idle ack", 32'(ack), 32'd0);
      cyc();
      chk("cap next sel",  32'(sel),       32'd0);
      chk("cap next busy", 32'(busy),      32'd1);
      chk("cap next ack",  32'(ack),       32'b0001);
      chk("cap drained",   32'(out_valid), 32'd0);
      last = 4'b0001;
      cyc();
      req = 4'b0000;
      #1;
      chk("cap r0 data", out_data,     32'h00000030);
      chk("cap r0 src",  32'(out_src), 32'd0);
      cyc();

      // reset during the second beat of a requester-1 burst
      req = 4'b0010; last = 4'b0000; d1 = 32'h00000100;
      cyc();
      chk("mid sel", 32'(sel), 32'd1);
      cyc();
      chk("mid beat1 valid", 32'(out_valid), 32'd1);
      d1 = 32'h00000101;
      #1;
      chk("mid beat2 ack", 32'(ack), 32'b0010);
      reset_n = 1'b0;
      #1;
      chk_reset_vals("mid reset");
      req = 4'b0011;
      cyc();
      reset_n = 1'b1;
      cyc();
      chk("post reset sel",  32'(sel),  32'd0);
      chk("post reset busy", 32'(busy), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
